// File: rtl/bus_rr_arbiter.sv
// Round-robin shared-bus arbiter for NUM_M masters and NUM_S slaves, with an optional burst limit.
// Slaves are decoded from the top address bits; read data returns one cycle later through a registered select.
module bus_rr_arbiter #(
  parameter int NUM_M     = 2,
  parameter int NUM_S     = 3,
  parameter int AW        = 16,
  parameter int DW        = 64,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_M-1:0]    m_req,
  input  logic [NUM_M-1:0]    m_wr,
  input  logic [NUM_M*AW-1:0] m_addr,
  input  logic [NUM_M*DW-1:0] m_dout,
  output logic [NUM_M-1:0]    m_grant,
  output logic [DW-1:0]       m_din,
  output logic [NUM_S-1:0]    s_sel,
  output logic                s_wr,
  output logic [AW-1:0]       s_addr,
  output logic [DW-1:0]       s_din,
  input  logic [NUM_S*DW-1:0] s_dout
);

  localparam int MB = $clog2((NUM_M > 2) ? NUM_M : 2);
  localparam int SB = $clog2((NUM_S > 2) ? NUM_S : 2);
  localparam int CW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

  typedef enum logic {IDLE, OWN} state_t;

  state_t         state_p0, state_n;
  logic [MB-1:0]  owner_p0, owner_n, last_p0, last_n, pick;
  logic [CW-1:0]  cnt_p0, cnt_n;
  logic           pick_vld, limit_hit, own_vld, wr_own, mapped;
  logic [NUM_M-1:0] cand;
  logic [SB-1:0]  idx, rd_sel_p1;
  logic           rd_vld_p1;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    if (int'(c) >= MAX_BURST) return c;
    return c + 1'b1;
  endfunction

  // Round-robin pick: scan from last+1; the current owner never competes against itself.
  always_comb begin
    cand = m_req;
    if (state_p0 == OWN) cand[owner_p0] = 1'b0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = 1; k <= NUM_M; k++) begin
      if (!pick_vld && cand[(int'(last_p0) + k) % NUM_M]) begin
        pick_vld = 1'b1;
        pick     = MB'((int'(last_p0) + k) % NUM_M);
      end
    end
  end

  assign limit_hit = (MAX_BURST != 0) && (int'(cnt_p0) == MAX_BURST - 1);

  always_comb begin
    state_n = state_p0;
    owner_n = owner_p0;
    last_n  = last_p0;
    cnt_n   = cnt_p0;
    case (state_p0)
      IDLE: begin
        if (pick_vld) begin
          state_n = OWN;
          owner_n = pick;
          last_n  = pick;
          cnt_n   = '0;
        end
      end
      OWN: begin
        if (!m_req[owner_p0] || (limit_hit && pick_vld)) begin
          if (pick_vld) begin
            owner_n = pick;
            last_n  = pick;
            cnt_n   = '0;
          end else begin
            state_n = IDLE;
            cnt_n   = '0;
          end
        end else if (!limit_hit) begin
          cnt_n = sat_inc(cnt_p0);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Stage p0: arbiter state; stage p1: read-return select.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0  <= IDLE;
      owner_p0  <= '0;
      last_p0   <= MB'(NUM_M - 1);
      cnt_p0    <= '0;
      rd_vld_p1 <= 1'b0;
    end else begin
      state_p0  <= state_n;
      owner_p0  <= owner_n;
      last_p0   <= last_n;
      cnt_p0    <= cnt_n;
      rd_vld_p1 <= own_vld && !wr_own && mapped;
    end
  end

  always_ff @(posedge clk) begin
    rd_sel_p1 <= idx;
  end

  assign own_vld = (state_p0 == OWN);

  always_comb begin
    s_addr = '0;
    s_din  = '0;
    wr_own = 1'b0;
    for (int i = 0; i < NUM_M; i++) begin
      if (own_vld && owner_p0 == MB'(i)) begin
        s_addr = m_addr[i*AW +: AW];
        s_din  = m_dout[i*DW +: DW];
        wr_own = m_wr[i];
      end
    end
  end

  assign idx    = s_addr[AW-1 -: SB];
  assign mapped = own_vld && (int'(idx) < NUM_S);
  assign s_wr   = wr_own && mapped;

  always_comb begin
    s_sel = '0;
    for (int k = 0; k < NUM_S; k++) s_sel[k] = mapped && (idx == SB'(k));
  end

  always_comb begin
    m_grant = '0;
    for (int i = 0; i < NUM_M; i++) m_grant[i] = own_vld && (owner_p0 == MB'(i));
  end

  always_comb begin
    m_din = '0;
    for (int k = 0; k < NUM_S; k++) begin
      if (rd_vld_p1 && rd_sel_p1 == SB'(k)) m_din = s_dout[k*DW +: DW];
    end
  end

endmodule
